// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD_E,
    STRETCH_E,
    RELEASE_E,
    DONE_E
  } rst_seq_state_t;

  function automatic int rst_seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-assert / sync-deassert reset synchroniser: a chain of flops cleared by rst_n and fed with 1.
module reset_synchronizer #(
  parameter int SYNC_STAGES_P = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES_P-1:0] sync_q;
  logic [SYNC_STAGES_P-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES_P-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES_P-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronised, stretched release of NR_OF_STAGES_P active-low resets with software re-trigger.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NR_OF_STAGES_P   = 3,
  parameter int SYNC_STAGES_P    = 2,
  parameter int STRETCH_CYCLES_P = 16,
  parameter int STAGE_DELAY_P    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_rst_req,
  output logic [NR_OF_STAGES_P-1:0] rst_n_out,
  output logic                      rst_done,
  output logic                      sw_rst_ack
);

  localparam int CNT_W = $clog2(rst_seq_max(STRETCH_CYCLES_P, STAGE_DELAY_P)) + 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES_P - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY_P - 1);

  if (NR_OF_STAGES_P < 1) begin : g_bad_stages
    $error("reset_sequencer: NR_OF_STAGES_P must be >= 1");
  end
  if (SYNC_STAGES_P < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES_P must be >= 2");
  end
  if (STRETCH_CYCLES_P < 1) begin : g_bad_stretch
    $error("reset_sequencer: STRETCH_CYCLES_P must be >= 1");
  end
  if (STAGE_DELAY_P < 1) begin : g_bad_delay
    $error("reset_sequencer: STAGE_DELAY_P must be >= 1");
  end

  logic rst_n_sync;

  reset_synchronizer #(
    .SYNC_STAGES_P(SYNC_STAGES_P)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_n_sync(rst_n_sync)
  );

  rst_seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NR_OF_STAGES_P-1:0] out_q, out_d;
  logic                      done_q, done_d;
  logic                      ack_q, ack_d;
  logic                      sw_origin_q, sw_origin_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    done_d      = done_q;
    ack_d       = 1'b0;
    sw_origin_d = sw_origin_q;
    case (state_q)
      HOLD_E: begin
        if (rst_n_sync) begin
          state_d = STRETCH_E;
          cnt_d   = '0;
        end
      end
      STRETCH_E: begin
        if (cnt_q == STRETCH_LAST) begin
          out_d    = '0;
          out_d[0] = 1'b1;
          state_d  = RELEASE_E;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE_E: begin
        // Done is entered one edge after the last stage release, so rst_done lags the final bit.
        if (&out_q) begin
          state_d     = DONE_E;
          cnt_d       = '0;
          done_d      = 1'b1;
          ack_d       = sw_origin_q;
          sw_origin_d = 1'b0;
        end else if (cnt_q == DELAY_LAST) begin
          out_d = (out_q << 1) | NR_OF_STAGES_P'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE_E: begin
        if (sw_rst_req) begin
          out_d       = '0;
          done_d      = 1'b0;
          sw_origin_d = 1'b1;
          state_d     = STRETCH_E;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = HOLD_E;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD_E;
      cnt_q       <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      sw_origin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      sw_origin_q <= sw_origin_d;
    end
  end

  assign rst_n_out  = out_q;
  assign rst_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 3-stage instance plus a 1-stage/1-cycle-stretch instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_rst_req;
  logic [2:0] rst_n_out;
  logic       rst_done;
  logic       sw_rst_ack;
  logic [0:0] rst_n_out1;
  logic       rst_done1;
  logic       sw_rst_ack1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NR_OF_STAGES_P(3), .SYNC_STAGES_P(2), .STRETCH_CYCLES_P(16), .STAGE_DELAY_P(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out), .rst_done(rst_done), .sw_rst_ack(sw_rst_ack)
  );

  reset_sequencer #(
    .NR_OF_STAGES_P(1), .SYNC_STAGES_P(2), .STRETCH_CYCLES_P(1), .STAGE_DELAY_P(8)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out1), .rst_done(rst_done1), .sw_rst_ack(sw_rst_ack1)
  );

  task automatic test_reset();
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL reset_out: got %b want 000", rst_n_out); end
    total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rst_done); end
    total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", sw_rst_ack); end
    total++; if (rst_n_out1 !== 1'b0) begin bad++; $display("FAIL reset_out1: got %b want 0", rst_n_out1); end
    total++; if (rst_done1 !== 1'b0) begin bad++; $display("FAIL reset_done1: got %b want 0", rst_done1); end
  endtask

  // Expects rst_n low on entry; releases it between edges so the next posedge is E1.
  task automatic test_power_on();
    logic [2:0] exp_out;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk);
      #1;
      exp_out = {k >= 35, k >= 27, k >= 19};
      total++; if (rst_n_out !== exp_out) begin bad++; $display("FAIL power_on_out E%0d: got %b want %b", k, rst_n_out, exp_out); end
      total++; if (rst_done !== (k >= 36)) begin bad++; $display("FAIL power_on_done E%0d: got %b want %b", k, rst_done, k >= 36); end
      total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL power_on_ack E%0d: got %b want 0", k, sw_rst_ack); end
      total++; if ((rst_n_out[2] & ~rst_n_out[1]) | (rst_n_out[1] & ~rst_n_out[0])) begin
        bad++; $display("FAIL monotonic E%0d: got %b want thermometer", k, rst_n_out);
      end
      total++; if (rst_n_out1 !== (k >= 4)) begin bad++; $display("FAIL single_out E%0d: got %b want %b", k, rst_n_out1, k >= 4); end
      total++; if (rst_done1 !== (k >= 5)) begin bad++; $display("FAIL single_done E%0d: got %b want %b", k, rst_done1, k >= 5); end
      total++; if (sw_rst_ack1 !== 1'b0) begin bad++; $display("FAIL single_ack E%0d: got %b want 0", k, sw_rst_ack1); end
    end
  endtask

  task automatic test_sw_reset();
    logic [2:0] exp_out;
    @(negedge clk);
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) sw_rst_req = 1'b0;
      exp_out = {k >= 32, k >= 24, k >= 16};
      total++; if (rst_n_out !== exp_out) begin bad++; $display("FAIL sw_out S+%0d: got %b want %b", k, rst_n_out, exp_out); end
      total++; if (rst_done !== (k >= 33)) begin bad++; $display("FAIL sw_done S+%0d: got %b want %b", k, rst_done, k >= 33); end
      total++; if (sw_rst_ack !== (k == 33)) begin bad++; $display("FAIL sw_ack S+%0d: got %b want %b", k, sw_rst_ack, k == 33); end
    end
  endtask

  task automatic test_rst_mid_release();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++; if (rst_n_out !== 3'b011) begin bad++; $display("FAIL mid_pre_out: got %b want 011", rst_n_out); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL mid_async_out: got %b want 000", rst_n_out); end
    total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL mid_async_done: got %b want 0", rst_done); end
    test_power_on();
  endtask

  task automatic test_ignored_request();
    logic [2:0] exp_out;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk);
      #1;
      if (k == 5)  sw_rst_req = 1'b1;
      if (k == 17) sw_rst_req = 1'b0;
      exp_out = {k >= 35, k >= 27, k >= 19};
      total++; if (rst_n_out !== exp_out) begin bad++; $display("FAIL ignored_out E%0d: got %b want %b", k, rst_n_out, exp_out); end
      total++; if (rst_done !== (k >= 36)) begin bad++; $display("FAIL ignored_done E%0d: got %b want %b", k, rst_done, k >= 36); end
      total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL ignored_ack E%0d: got %b want 0", k, sw_rst_ack); end
    end
  endtask

  // Held request: sample edge S, ack at S+33, next DONE cycle re-samples at S+34.
  task automatic test_held_request();
    logic exp_done;
    logic exp_ack;
    @(negedge clk);
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 105; k++) begin
      @(posedge clk);
      #1;
      exp_ack  = ((k % 34) == 33);
      exp_done = (k >= 101) ? 1'b1 : exp_ack;
      total++; if (rst_done !== exp_done) begin bad++; $display("FAIL held_done S+%0d: got %b want %b", k, rst_done, exp_done); end
      total++; if (sw_rst_ack !== exp_ack) begin bad++; $display("FAIL held_ack S+%0d: got %b want %b", k, sw_rst_ack, exp_ack); end
      if (k == 101) sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_rst_during_sw();
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(posedge clk);
    #1;
    sw_rst_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (rst_n_out !== 3'b001) begin bad++; $display("FAIL rst_sw_pre_out: got %b want 001", rst_n_out); end
    rst_n = 1'b0;
    #1;
    total++; if (rst_n_out !== 3'b000) begin bad++; $display("FAIL rst_sw_async_out: got %b want 000", rst_n_out); end
    total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL rst_sw_async_ack: got %b want 0", sw_rst_ack); end
    test_power_on();
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_rst_mid_release();
    test_ignored_request();
    test_held_request();
    test_rst_during_sw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
